// File: rtl/lcd12864_pkg.sv
// ============================================================================
// Module      : lcd12864_pkg
// Description : Shared types and constants for the LCD12864 (ST7920, 8-bit
//               parallel) bus writer: FSM state encoding, default timing in
//               50 MHz clock cycles, and common panel command bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd12864_pkg;

    // Engine states
    typedef enum logic [2:0] {
        ST_POR_WAIT = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_PULSE    = 3'd3,
        ST_HOLD     = 3'd4,
        ST_EXEC     = 3'd5
    } lcd_state_t;

    // Default timing at 50 MHz
    localparam int DEF_TPOR_CYC   = 2_000_000;  // 40 ms power-on wait
    localparam int DEF_TAS_CYC    = 4;          // address/data setup
    localparam int DEF_TPW_CYC    = 16;         // enable pulse width
    localparam int DEF_TH_CYC     = 4;          // address/data hold
    localparam int DEF_TCMD_CYC   = 4000;       // 80 us execution
    localparam int DEF_TCLR_CYC   = 80_000;     // 1.6 ms clear execution
    localparam int DEF_FIFO_DEPTH = 8;

    // ST7920 command bytes
    localparam logic [7:0] CMD_FUNC_8BIT = 8'h30;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_LINE1     = 8'h80;
    localparam logic [7:0] CMD_LINE2     = 8'h90;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd12864_fifo.sv
// ============================================================================
// Module      : lcd12864_fifo
// Description : Small synchronous FIFO holding {rs, data} entries in front of
//               the bus-writer engine. Show-ahead read port (rdata is the
//               head entry whenever empty is low). A push while full is
//               accepted when a pop happens in the same cycle.
//               DEPTH must be a power of two and at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd12864_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array, no reset needed since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/lcd12864_bus_writer.sv
// ============================================================================
// Module      : lcd12864_bus_writer
// Description : ST7920 8-bit parallel write engine. Accepts {rs, data} bytes
//               over valid/ready and sequences dat/rs/en with setup, pulse,
//               hold and execution delays, including the power-on wait and
//               the long clear-display delay.
//               Optional input FIFO: define LCD12864_FIFO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd12864_bus_writer
    import lcd12864_pkg::*;
#(
    parameter int TPOR_CYC   = DEF_TPOR_CYC,
    parameter int TAS_CYC    = DEF_TAS_CYC,
    parameter int TPW_CYC    = DEF_TPW_CYC,
    parameter int TH_CYC     = DEF_TH_CYC,
    parameter int TCMD_CYC   = DEF_TCMD_CYC,
    parameter int TCLR_CYC   = DEF_TCLR_CYC,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic [7:0] dat,
    output logic       rs,
    output logic       rw,
    output logic       en
);

    localparam int MAX_T = max_int(max_int(max_int(TPOR_CYC, TAS_CYC), max_int(TPW_CYC, TH_CYC)),
                                   max_int(TCMD_CYC, TCLR_CYC));
    localparam int CW    = $clog2(MAX_T) + 1;

    lcd_state_t r_state;
    lcd_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_load;
    logic          w_cnt_done;
    logic          w_take;
    logic          w_have_byte;
    logic          w_byte_rs;
    logic [7:0]    w_byte_data;
    logic          w_fifo_empty;
    logic          w_is_clear;
    logic          r_rs;
    logic [7:0]    r_dat;

`ifdef LCD12864_FIFO_EN
    logic          w_fifo_full;
    logic [8:0]    w_fifo_rdata;

    lcd12864_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .wdata ({in_rs, in_data}),
        .full  (w_fifo_full),
        .pop   (w_take),
        .rdata (w_fifo_rdata),
        .empty (w_fifo_empty)
    );

    assign w_have_byte = !w_fifo_empty;
    assign w_byte_rs   = w_fifo_rdata[8];
    assign w_byte_data = w_fifo_rdata[7:0];
`else
    assign w_have_byte  = in_valid;
    assign w_byte_rs    = in_rs;
    assign w_byte_data  = in_data;
    assign w_fifo_empty = 1'b1;
`endif

    assign w_take     = (r_state == ST_IDLE) && w_have_byte;
    assign w_cnt_done = (r_cnt == '0);
    // Only a command-register 0x01 gets the long execution delay
    assign w_is_clear = !r_rs && (r_dat == CMD_CLEAR);

    // State register and shared down-counter, reloaded on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_POR_WAIT;
            r_cnt   <= CW'(TPOR_CYC - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (!w_cnt_done) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Next-state logic and counter reload value for the state being entered
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_POR_WAIT: if (w_cnt_done) w_state_nxt = ST_IDLE;
            ST_IDLE:     if (w_take)     w_state_nxt = ST_SETUP;
            ST_SETUP:    if (w_cnt_done) w_state_nxt = ST_PULSE;
            ST_PULSE:    if (w_cnt_done) w_state_nxt = ST_HOLD;
            ST_HOLD:     if (w_cnt_done) w_state_nxt = ST_EXEC;
            ST_EXEC:     if (w_cnt_done) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_POR_WAIT;
        endcase

        w_cnt_load = '0;
        case (w_state_nxt)
            ST_POR_WAIT: w_cnt_load = CW'(TPOR_CYC - 1);
            ST_SETUP:    w_cnt_load = CW'(TAS_CYC - 1);
            ST_PULSE:    w_cnt_load = CW'(TPW_CYC - 1);
            ST_HOLD:     w_cnt_load = CW'(TH_CYC - 1);
            ST_EXEC:     w_cnt_load = w_is_clear ? CW'(TCLR_CYC - 1) : CW'(TCMD_CYC - 1);
            default:     w_cnt_load = '0;
        endcase
    end

    // Byte latch: rs/dat change only when a new byte enters SETUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs  <= 1'b0;
            r_dat <= 8'h00;
        end else if (w_take) begin
            r_rs  <= w_byte_rs;
            r_dat <= w_byte_data;
        end
    end

    // Output decode; en follows the state register so reset drops it at once
    always_comb begin
        en   = (r_state == ST_PULSE);
        busy = (r_state != ST_IDLE) || !w_fifo_empty;
`ifdef LCD12864_FIFO_EN
        in_ready = !w_fifo_full;
`else
        in_ready = (r_state == ST_IDLE);
`endif
    end

    assign rs  = r_rs;
    assign dat = r_dat;
    assign rw  = 1'b0;

endmodule

`default_nettype wire
